// File: rtl/decode_stage_pipelined.sv
// decode_stage_pipelined
//   Pipelined instruction decode stage. Decodes one instruction per cycle,
//   owns the register file (with write-through bypass from write-back),
//   sign-extends the immediate and resolves branches and jumps in ID.
//   Detects load-use and branch-operand hazards against the instruction in
//   EX, stalls IF for one cycle when one is found, and registers the decoded
//   instruction into the ID/EX boundary.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   if_valid/instruc/pc   IF/ID contents (if_pc = next sequential address)
//   wb_reg_write/rw/busw  register-file write port from write-back
//   stall, flush          hold IF / squash IF/ID
//   branch_sel/address    taken branch and its target
//   jump_sel/address      jump and its target
//   ex_*, m_control,
//   wb_control            registered ID/EX boundary
module decode_stage_pipelined #(
   parameter int DATA_W   = 32,
   parameter int PC_W     = 10,
   parameter int NUM_REGS = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_valid,
   input  logic [31:0]       if_instruc,
   input  logic [PC_W-1:0]   if_pc,
   input  logic              wb_reg_write,
   input  logic [4:0]        wb_rw,
   input  logic [DATA_W-1:0] wb_busw,
   output logic              stall,
   output logic              flush,
   output logic              branch_sel,
   output logic [PC_W-1:0]   branch_address,
   output logic              jump_sel,
   output logic [PC_W-1:0]   jump_address,
   output logic              ex_valid,
   output logic [3:0]        ex_control,
   output logic [1:0]        m_control,
   output logic [1:0]        wb_control,
   output logic [DATA_W-1:0] ex_bus_a,
   output logic [DATA_W-1:0] ex_bus_b,
   output logic [DATA_W-1:0] ex_immed,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd,
   output logic [PC_W-1:0]   ex_pc
);

   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   typedef enum logic [5:0] {
      OP_RTYPE = 6'b000000,
      OP_LW    = 6'b100011,
      OP_SW    = 6'b101011,
      OP_ADDI  = 6'b001000,
      OP_BEQ   = 6'b000100,
      OP_BNE   = 6'b000101,
      OP_J     = 6'b000010
   } opcode_e;

   typedef struct packed {
      logic              valid;
      logic [3:0]        ex_ctl;   // {reg_dst, alu_src, alu_op[1:0]}
      logic [1:0]        m_ctl;    // {mem_read, mem_write}
      logic [1:0]        wb_ctl;   // {reg_write, mem_to_reg}
      logic [DATA_W-1:0] bus_a;
      logic [DATA_W-1:0] bus_b;
      logic [DATA_W-1:0] immed;
      logic [4:0]        rs;
      logic [4:0]        rt;
      logic [4:0]        rd;
      logic [PC_W-1:0]   pc;
   } idex_t;

   idex_t             idex_q, idex_d;
   logic [DATA_W-1:0] regs_q [NUM_REGS];

   // Instruction fields
   logic [5:0]        opcode;
   logic [4:0]        rs, rt, rd;
   logic [DATA_W-1:0] immed;

   // Decoded control
   logic [3:0] dec_ex;
   logic [1:0] dec_m, dec_wb;
   logic       uses_rs, uses_rt, is_beq, is_bne, is_j;

   // Operands and hazard terms
   logic [DATA_W-1:0] bus_a, bus_b;
   logic [4:0]        ex_dest;
   logic              load_use, branch_haz, cmp_eq;

   always_comb begin
      opcode = if_instruc[31:26];
      rs     = if_instruc[25:21];
      rt     = if_instruc[20:16];
      rd     = if_instruc[15:11];
      immed  = {{(DATA_W-16){if_instruc[15]}}, if_instruc[15:0]};
   end

   always_comb begin
      dec_ex  = '0;
      dec_m   = '0;
      dec_wb  = '0;
      uses_rs = 1'b0;
      uses_rt = 1'b0;
      is_beq  = 1'b0;
      is_bne  = 1'b0;
      is_j    = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            dec_ex  = 4'b1010;
            dec_wb  = 2'b10;
            uses_rs = 1'b1;
            uses_rt = 1'b1;
         end
         OP_LW: begin
            dec_ex  = 4'b0100;
            dec_m   = 2'b10;
            dec_wb  = 2'b11;
            uses_rs = 1'b1;
         end
         OP_SW: begin
            dec_ex  = 4'b0100;
            dec_m   = 2'b01;
            uses_rs = 1'b1;
            uses_rt = 1'b1;
         end
         OP_ADDI: begin
            dec_ex  = 4'b0100;
            dec_wb  = 2'b10;
            uses_rs = 1'b1;
         end
         OP_BEQ: begin
            dec_ex  = 4'b0001;
            uses_rs = 1'b1;
            uses_rt = 1'b1;
            is_beq  = 1'b1;
         end
         OP_BNE: begin
            dec_ex  = 4'b0001;
            uses_rs = 1'b1;
            uses_rt = 1'b1;
            is_bne  = 1'b1;
         end
         OP_J:    is_j = 1'b1;
         default: ;
      endcase
   end

   // Register read with write-through: a write landing this cycle is seen by
   // the reader immediately. r0 and unimplemented indices always read zero,
   // and writes to them never hit the bypass either.
   always_comb begin
      bus_a = '0;
      if (rs != 5'd0 && 32'(rs) < 32'(NUM_REGS)) begin
         if (wb_reg_write && wb_rw == rs) bus_a = wb_busw;
         else                             bus_a = regs_q[rs[IDX_W-1:0]];
      end
   end

   always_comb begin
      bus_b = '0;
      if (rt != 5'd0 && 32'(rt) < 32'(NUM_REGS)) begin
         if (wb_reg_write && wb_rw == rt) bus_b = wb_busw;
         else                             bus_b = regs_q[rt[IDX_W-1:0]];
      end
   end

   // Register file; entry 0 is held at zero and never written.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (wb_reg_write && wb_rw == 5'(i)) regs_q[i] <= wb_busw;
         end
      end
   end

   // Hazards against the instruction currently in EX. A load's target is its
   // rt; for the branch check the real destination depends on reg_dst.
   always_comb begin
      ex_dest    = idex_q.ex_ctl[3] ? idex_q.rd : idex_q.rt;
      load_use   = idex_q.m_ctl[1] && (idex_q.rt != 5'd0) &&
                   ((uses_rs && rs == idex_q.rt) || (uses_rt && rt == idex_q.rt));
      branch_haz = (is_beq || is_bne) && idex_q.wb_ctl[1] && (ex_dest != 5'd0) &&
                   ((ex_dest == rs) || (ex_dest == rt));
      stall      = if_valid && idex_q.valid && (load_use || branch_haz);
   end

   always_comb begin
      cmp_eq         = (bus_a == bus_b);
      branch_sel     = if_valid && !stall && ((is_beq && cmp_eq) || (is_bne && !cmp_eq));
      jump_sel       = if_valid && !stall && is_j;
      flush          = branch_sel || jump_sel;
      branch_address = if_pc + immed[PC_W-1:0];
      jump_address   = if_instruc[PC_W-1:0];
   end

   // Stalled or empty slots enter EX as an all-zero bubble.
   always_comb begin
      idex_d = '0;
      if (if_valid && !stall) begin
         idex_d.valid  = 1'b1;
         idex_d.ex_ctl = dec_ex;
         idex_d.m_ctl  = dec_m;
         idex_d.wb_ctl = dec_wb;
         idex_d.bus_a  = bus_a;
         idex_d.bus_b  = bus_b;
         idex_d.immed  = immed;
         idex_d.rs     = rs;
         idex_d.rt     = rt;
         idex_d.rd     = rd;
         idex_d.pc     = if_pc;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) idex_q <= '0;
      else        idex_q <= idex_d;
   end

   always_comb begin
      ex_valid   = idex_q.valid;
      ex_control = idex_q.ex_ctl;
      m_control  = idex_q.m_ctl;
      wb_control = idex_q.wb_ctl;
      ex_bus_a   = idex_q.bus_a;
      ex_bus_b   = idex_q.bus_b;
      ex_immed   = idex_q.immed;
      ex_rs      = idex_q.rs;
      ex_rt      = idex_q.rt;
      ex_rd      = idex_q.rd;
      ex_pc      = idex_q.pc;
   end

endmodule

// File: tb/tb_decode_stage_pipelined.sv
module tb_decode_stage_pipelined;

   localparam int DATA_W   = 32;
   localparam int PC_W     = 10;
   localparam int NUM_REGS = 32;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              if_valid, wb_reg_write;
   logic [31:0]       if_instruc;
   logic [PC_W-1:0]   if_pc;
   logic [4:0]        wb_rw;
   logic [DATA_W-1:0] wb_busw;
   logic              stall, flush, branch_sel, jump_sel, ex_valid;
   logic [PC_W-1:0]   branch_address, jump_address, ex_pc;
   logic [3:0]        ex_control;
   logic [1:0]        m_control, wb_control;
   logic [DATA_W-1:0] ex_bus_a, ex_bus_b, ex_immed;
   logic [4:0]        ex_rs, ex_rt, ex_rd;

   decode_stage_pipelined #(.DATA_W(DATA_W), .PC_W(PC_W), .NUM_REGS(NUM_REGS)) dut (
      .clock(clock), .reset(reset), .if_valid(if_valid), .if_instruc(if_instruc),
      .if_pc(if_pc), .wb_reg_write(wb_reg_write), .wb_rw(wb_rw), .wb_busw(wb_busw),
      .stall(stall), .flush(flush), .branch_sel(branch_sel),
      .branch_address(branch_address), .jump_sel(jump_sel), .jump_address(jump_address),
      .ex_valid(ex_valid), .ex_control(ex_control), .m_control(m_control),
      .wb_control(wb_control), .ex_bus_a(ex_bus_a), .ex_bus_b(ex_bus_b),
      .ex_immed(ex_immed), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_pc(ex_pc)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic iv, input logic [31:0] ins, input logic [PC_W-1:0] pc,
                        input logic we, input logic [4:0] rw, input logic [DATA_W-1:0] bd);
      if_valid = iv; if_instruc = ins; if_pc = pc;
      wb_reg_write = we; wb_rw = rw; wb_busw = bd;
   endtask

   // Inputs change 1 time unit after a rising edge; registered outputs are
   // sampled at that same point, combinational outputs 3 units later.
   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // ---------------- table-driven decode vectors ----------------
   typedef struct {
      string           name;
      logic [31:0]     ins;
      logic [PC_W-1:0] pc;
      logic [3:0]      exc;
      logic [1:0]      mc, wbc;
      logic [31:0]     imm;
      logic            bs, js;
      logic [PC_W-1:0] baddr, jaddr;
   } vec_t;

   vec_t tbl[8];

   // ---------------- reference model ----------------
   typedef struct packed {
      logic v; logic [3:0] exc; logic [1:0] mc, wbc;
      logic [31:0] a, b, imm; logic [4:0] rs, rt, rd; logic [PC_W-1:0] pc;
   } ex_t;

   logic [31:0] mregs [32];
   ex_t         mex;

   function automatic logic [7:0] mdecode(input logic [5:0] op);
      case (op)
         6'h00:       return 8'b1010_00_10;
         6'h23:       return 8'b0100_10_11;
         6'h2B:       return 8'b0100_01_00;
         6'h08:       return 8'b0100_00_10;
         6'h04, 6'h05: return 8'b0001_00_00;
         default:     return 8'b0;
      endcase
   endfunction

   function automatic logic [31:0] mread(input logic [4:0] i, input logic we,
                                         input logic [4:0] rw, input logic [31:0] bd);
      if (i == 5'd0 || int'(i) >= NUM_REGS) return 32'd0;
      if (we && rw == i) return bd;
      return mregs[i];
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0]  op;
      logic [4:0]  rs, rt, rd, rw, dest;
      logic [31:0] ins, a, b, bd;
      logic [PC_W-1:0] pc;
      logic        iv, we, st, bs, js, src_rs, src_rt, is_br, lu, bh;
      ex_t         nx;

      tbl[0] = '{"rtype", 32'h00452020, 10'h100, 4'b1010, 2'b00, 2'b10, 32'h00002020, 1'b0, 1'b0, 10'h120, 10'h020};
      tbl[1] = '{"lw",    32'h8C220008, 10'h004, 4'b0100, 2'b10, 2'b11, 32'h00000008, 1'b0, 1'b0, 10'h00C, 10'h008};
      tbl[2] = '{"sw",    32'hAC22FFFC, 10'h008, 4'b0100, 2'b01, 2'b00, 32'hFFFFFFFC, 1'b0, 1'b0, 10'h004, 10'h3FC};
      tbl[3] = '{"addi",  32'h20010005, 10'h00C, 4'b0100, 2'b00, 2'b10, 32'h00000005, 1'b0, 1'b0, 10'h011, 10'h005};
      tbl[4] = '{"beq",   32'h10220004, 10'h010, 4'b0001, 2'b00, 2'b00, 32'h00000004, 1'b1, 1'b0, 10'h014, 10'h004};
      tbl[5] = '{"bne",   32'h14220004, 10'h3FE, 4'b0001, 2'b00, 2'b00, 32'h00000004, 1'b0, 1'b0, 10'h002, 10'h004};
      tbl[6] = '{"j",     32'h080003FF, 10'h020, 4'b0000, 2'b00, 2'b00, 32'h000003FF, 1'b0, 1'b1, 10'h01F, 10'h3FF};
      tbl[7] = '{"nop",   32'hFC000000, 10'h030, 4'b0000, 2'b00, 2'b00, 32'h00000000, 1'b0, 1'b0, 10'h030, 10'h000};

      // Reset held low with a valid instruction present
      drive(1'b1, 32'h20010005, 10'h004, 1'b0, 5'd0, '0);
      #3;
      chk("rst_stall", stall, 0);
      tick;
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_ex_control", ex_control, 0);
      chk("rst_ex_immed", ex_immed, 0);
      chk("rst_ex_pc", ex_pc, 0);
      reset = 1'b1;
      #3;
      chk("addi_stall", stall, 0);
      tick;
      chk("addi_ex_valid", ex_valid, 1);
      chk("addi_ex_immed", ex_immed, 5);
      chk("addi_wb_control", wb_control, 2'b10);
      chk("addi_ex_control", ex_control, 4'b0100);
      drive(1'b0, '0, '0, 1'b0, 5'd0, '0);
      tick;
      chk("idle_ex_valid", ex_valid, 0);

      // Table: each vector decoded with an empty EX, followed by an idle slot
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, tbl[i].ins, tbl[i].pc, 1'b0, 5'd0, '0);
         #3;
         chk({tbl[i].name, "_stall"}, stall, 0);
         chk({tbl[i].name, "_branch_sel"}, branch_sel, tbl[i].bs);
         chk({tbl[i].name, "_jump_sel"}, jump_sel, tbl[i].js);
         chk({tbl[i].name, "_flush"}, flush, tbl[i].bs | tbl[i].js);
         chk({tbl[i].name, "_branch_address"}, branch_address, tbl[i].baddr);
         chk({tbl[i].name, "_jump_address"}, jump_address, tbl[i].jaddr);
         tick;
         chk({tbl[i].name, "_ex_valid"}, ex_valid, 1);
         chk({tbl[i].name, "_ex_control"}, ex_control, tbl[i].exc);
         chk({tbl[i].name, "_m_control"}, m_control, tbl[i].mc);
         chk({tbl[i].name, "_wb_control"}, wb_control, tbl[i].wbc);
         chk({tbl[i].name, "_ex_immed"}, ex_immed, tbl[i].imm);
         chk({tbl[i].name, "_ex_pc"}, ex_pc, tbl[i].pc);
         drive(1'b0, '0, '0, 1'b0, 5'd0, '0);
         tick;
      end

      // Write-through bypass, then stored value, then ignored write to r0
      drive(1'b1, 32'h00603020, 10'h040, 1'b1, 5'd3, 32'h1234);
      tick;
      chk("bypass_bus_a", ex_bus_a, 32'h1234);
      drive(1'b1, 32'h00603020, 10'h044, 1'b0, 5'd0, '0);
      tick;
      chk("stored_bus_a", ex_bus_a, 32'h1234);
      drive(1'b1, 32'h00003020, 10'h048, 1'b1, 5'd0, 32'hDEAD);
      tick;
      chk("r0_bus_a", ex_bus_a, 0);

      // Load-use: LW r2 then ADD r4,r2,r5
      drive(1'b0, '0, '0, 1'b0, 5'd0, '0);
      tick;
      drive(1'b1, 32'h8C220000, 10'h050, 1'b0, 5'd0, '0);
      tick;
      drive(1'b1, 32'h00452020, 10'h054, 1'b0, 5'd0, '0);
      #3;
      chk("lu_stall", stall, 1);
      chk("lu_flush", flush, 0);
      tick;
      chk("lu_bubble_valid", ex_valid, 0);
      chk("lu_bubble_ctrl", ex_control, 0);
      #3;
      chk("lu_stall_clear", stall, 0);
      tick;
      chk("lu_add_valid", ex_valid, 1);
      chk("lu_add_rs", ex_rs, 2);
      chk("lu_add_pc", ex_pc, 10'h054);

      // Branch operand hazard: ADDI r7 then BEQ r7,r7; resolves with bypass
      drive(1'b0, '0, '0, 1'b0, 5'd0, '0);
      tick;
      drive(1'b1, 32'h20070009, 10'h060, 1'b0, 5'd0, '0);
      tick;
      drive(1'b1, 32'h10E70004, 10'h064, 1'b0, 5'd0, '0);
      #3;
      chk("bh_stall", stall, 1);
      chk("bh_branch_sel", branch_sel, 0);
      chk("bh_flush", flush, 0);
      tick;
      chk("bh_bubble_valid", ex_valid, 0);
      drive(1'b1, 32'h10E70004, 10'h064, 1'b1, 5'd7, 32'd9);
      #3;
      chk("bh_stall_clear", stall, 0);
      chk("bh_taken", branch_sel, 1);
      chk("bh_flush_taken", flush, 1);
      chk("bh_address", branch_address, 10'h068);
      tick;
      chk("bh_ex_bus_a", ex_bus_a, 9);
      chk("bh_ex_control", ex_control, 4'b0001);

      // Asynchronous reset in the middle of a stall
      drive(1'b0, '0, '0, 1'b0, 5'd0, '0);
      tick;
      drive(1'b1, 32'h8C220000, 10'h070, 1'b0, 5'd0, '0);
      tick;
      drive(1'b1, 32'h00452020, 10'h074, 1'b0, 5'd0, '0);
      #3;
      chk("mid_stall", stall, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("async_stall", stall, 0);
      chk("async_ex_valid", ex_valid, 0);
      chk("async_m_control", m_control, 0);
      chk("async_ex_rt", ex_rt, 0);
      tick;
      reset = 1'b1;
      drive(1'b1, 32'h00603020, 10'h080, 1'b0, 5'd0, '0);
      tick;
      chk("rf_cleared", ex_bus_a, 0);

      // Randomized run against the reference model, from a fresh reset
      reset = 1'b0;
      #2;
      reset = 1'b1;
      for (int i = 0; i < 32; i++) mregs[i] = '0;
      mex = '0;
      for (int n = 0; n < 500; n++) begin
         case ($urandom_range(0, 8))
            0, 7:    op = 6'h00;
            1:       op = 6'h23;
            2:       op = 6'h2B;
            3:       op = 6'h08;
            4:       op = 6'h04;
            5:       op = 6'h05;
            6:       op = 6'h02;
            default: op = 6'($urandom_range(0, 63));
         endcase
         rs  = 5'($urandom_range(0, 7));
         rt  = 5'($urandom_range(0, 7));
         rd  = 5'($urandom_range(0, 7));
         ins = {op, rs, rt, rd, 11'($urandom)};
         pc  = 10'($urandom);
         iv  = ($urandom_range(0, 9) != 0);
         we  = 1'($urandom_range(0, 1));
         rw  = 5'($urandom_range(0, 7));
         bd  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
         drive(iv, ins, pc, we, rw, bd);

         a      = mread(rs, we, rw, bd);
         b      = mread(rt, we, rw, bd);
         is_br  = (op == 6'h04) || (op == 6'h05);
         src_rs = (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h08) || is_br;
         src_rt = (op == 6'h00) || (op == 6'h2B) || is_br;
         dest   = mex.exc[3] ? mex.rd : mex.rt;
         lu = mex.mc[1] && (mex.rt != 0) && ((src_rs && rs == mex.rt) || (src_rt && rt == mex.rt));
         bh = is_br && mex.wbc[1] && (dest != 0) && (dest == rs || dest == rt);
         st = iv && mex.v && (lu || bh);
         bs = iv && !st && (((op == 6'h04) && (a == b)) || ((op == 6'h05) && (a != b)));
         js = iv && !st && (op == 6'h02);

         nx = '0;
         if (iv && !st) begin
            nx.v = 1'b1;
            {nx.exc, nx.mc, nx.wbc} = mdecode(op);
            nx.a = a; nx.b = b; nx.imm = {{16{ins[15]}}, ins[15:0]};
            nx.rs = rs; nx.rt = rt; nx.rd = rd; nx.pc = pc;
         end

         #3;
         chk("rnd_stall", stall, st);
         chk("rnd_branch_sel", branch_sel, bs);
         chk("rnd_jump_sel", jump_sel, js);
         chk("rnd_flush", flush, bs | js);
         chk("rnd_branch_address", branch_address, PC_W'(pc + ins[9:0]));
         chk("rnd_jump_address", jump_address, ins[9:0]);
         tick;
         chk("rnd_ex_valid", ex_valid, nx.v);
         chk("rnd_ex_control", ex_control, nx.exc);
         chk("rnd_m_control", m_control, nx.mc);
         chk("rnd_wb_control", wb_control, nx.wbc);
         chk("rnd_ex_bus_a", ex_bus_a, nx.a);
         chk("rnd_ex_bus_b", ex_bus_b, nx.b);
         chk("rnd_ex_immed", ex_immed, nx.imm);
         chk("rnd_ex_regs", {ex_rs, ex_rt, ex_rd}, {nx.rs, nx.rt, nx.rd});
         chk("rnd_ex_pc", ex_pc, nx.pc);

         if (we && rw != 0 && int'(rw) < NUM_REGS) mregs[rw] = bd;
         mex = nx;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode_stage_pipelined.md
Name: decode_stage_pipelined

Overview:
- Parametrised successor of the single-cycle decode block: decodes one instruction per cycle and owns the register file, sign extension, branch/jump resolution and control generation.
- Adds a registered ID/EX pipeline boundary, load-use and branch-operand hazard detection with stall, IF flush on taken control transfer, and write-through register-file bypass.
- Sits between the fetch stage (IF/ID outputs) and the execute stage.

Parameters:
- DATA_W, 32, register and bus width.
- PC_W, 10, PC width (matches `PC_SIZE+1`).
- NUM_REGS, 32, implemented registers (power of 2, max 32). Indices >= NUM_REGS read 0; writes to them are ignored.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- if_valid  in  1  IF/ID holds a real instruction
- if_instruc  in  32  instruction word
- if_pc  in  PC_W  address of the next sequential instruction
- wb_reg_write  in  1  write-back enable
- wb_rw  in  5  write-back register index
- wb_busw  in  DATA_W  write-back data
- stall  out  1  IF must hold PC and IF/ID
- flush  out  1  IF must squash IF/ID next edge
- branch_sel  out  1  take branch_address
- branch_address  out  PC_W  if_pc + immed[PC_W-1:0], modulo 2^PC_W
- jump_sel  out  1  take jump_address
- jump_address  out  PC_W  if_instruc[PC_W-1:0]
- ex_valid  out  1  ID/EX holds a real instruction
- ex_control  out  4  {reg_dst, alu_src, alu_op[1:0]}
- m_control  out  2  {mem_read, mem_write}
- wb_control  out  2  {reg_write, mem_to_reg}
- ex_bus_a, ex_bus_b  out  DATA_W  registered operands
- ex_immed  out  DATA_W  registered sign-extended imm[15:0]
- ex_rs, ex_rt, ex_rd  out  5 each  registered instr[25:21], [20:16], [15:11]
- ex_pc  out  PC_W  registered if_pc

Behaviour:
- Decode (opcode = instr[31:26]) -> EX/M/WB control:
  - 000000 R-type: 1010 / 00 / 10
  - 100011 LW: 0100 / 10 / 11
  - 101011 SW: 0100 / 01 / 00
  - 001000 ADDI: 0100 / 00 / 10
  - 000100 BEQ and 000101 BNE: 0001 / 00 / 00
  - 000010 J: all zero, jump_sel candidate
  - Any other opcode: all zero (NOP)
- Register file:
  - Written on rising edge when wb_reg_write=1 and wb_rw!=0; r0 always reads 0.
  - Same-cycle read of wb_rw returns wb_busw (write-through bypass).
  - All registers clear on reset.
- Sign extension: immed = {(DATA_W-16){instr[15]}, instr[15:0]}.
- Instruction uses rt as a source: R-type, SW, BEQ, BNE. Uses rs: all except J and NOP.
- EX destination: ex_rd when reg_dst=1, else ex_rt.
- stall=1 when if_valid and ex_valid and either:
  - Load-use: mem_read=1 in EX, ex_rt!=0, and ex_rt matches a used source of the ID instruction.
  - Branch operand: ID holds BEQ/BNE, reg_write=1 in EX, EX destination !=0 and matches ID rs or rt.
- Branch/jump resolution:
  - cmp = (bus_a == bus_b) after bypass.
  - branch_sel = if_valid & !stall & ((BEQ & cmp) | (BNE & !cmp)).
  - jump_sel = if_valid & !stall & J.
  - flush = branch_sel | jump_sel.
- ID/EX update on every rising edge:
  - When stall=1 or if_valid=0: load a bubble (ex_valid=0, all control 0, data fields don't-care but deterministic: 0).
  - Otherwise: ex_valid=1 and all fields take the current decoded values.
  - Taken branches and jumps still enter ID/EX with their own (inert) control.
- Latency: one cycle from IF/ID to ID/EX. Stall lasts exactly one cycle per hazard because the hazarding instruction leaves EX.
- Reset, async assert at any time, including mid-stall:
  - All ID/EX outputs 0, ex_valid=0, register file 0.
  - Combinational outputs follow inputs with an empty EX, so stall=0.
  - Release is synchronous to clock.
- Simultaneous WB write and ID read of the same register: bypassed data is used both for operands and for the branch compare.

Test Plan:
- Reset low with if_valid=1: all ex_* = 0, stall=0. After release, ADDI r1,r0,5 -> next cycle ex_valid=1, ex_immed=5, wb_control=10.
- WB writes r3=0x1234 while ID decodes R-type reading r3 -> ex_bus_a=0x1234 in the same cycle (bypass). A write to r0 is ignored: ex_bus_a=0.
- LW r2 in EX, ID holds ADD r4,r2,r5 -> stall=1 for one cycle and a bubble enters EX. The next cycle stall=0 and the ADD enters.
- BEQ r1,r1,+4 with if_pc=0x010 -> branch_sel=1, branch_address=0x014, flush=1. BNE with equal operands -> branch_sel=0.
- J with instr[9:0]=0x3FF -> jump_sel=1, jump_address=0x3FF, flush=1.
- ADDI r7 in EX, BEQ r7,r0 in ID -> stall=1 and branch_sel=0. On the next cycle the branch resolves.
